// File: rtl/toast_mem_arbiter.sv
// Single-port memory arbiter: MEM has fixed priority over IF, one bus transaction
// in flight, flush-drop of fetch results and a per-transaction no-ack timeout.
module toast_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    flush_i,
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH/8-1:0] mem_be_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic                    mem_gnt_o,
    output logic                    mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    input  logic                    bus_ack_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    output logic                    stall_o,
    output logic                    err_o
);
    localparam int          BE_W = DATA_WIDTH / 8;
    localparam logic [15:0] TMO  = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t                  state_q, state_d;
    logic                    drop_q, drop_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [BE_W-1:0]         bus_be_q, bus_be_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic                    if_rvalid_q, if_rvalid_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic                    mem_rvalid_q, mem_rvalid_d;
    logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
    logic                    err_q, err_d;
    logic                    if_gnt, mem_gnt, timeout, done, drop_eff;

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rvalid_d = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        err_d        = 1'b0;
        if_gnt       = 1'b0;
        mem_gnt      = 1'b0;
        timeout      = 1'b0;
        done         = 1'b0;
        // A flush in the completion cycle itself still discards the fetch.
        drop_eff     = drop_q | flush_i;

        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    mem_gnt     = 1'b1;
                    state_d     = BUSY_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_be_d    = mem_be_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    cnt_d       = '0;
                    drop_d      = 1'b0;
                end else if (if_req_i) begin
                    if_gnt      = 1'b1;
                    state_d     = BUSY_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                    cnt_d       = '0;
                    drop_d      = flush_i;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                timeout = (TMO != 16'd0) && (cnt_q == TMO) && !bus_ack_i;
                done    = bus_ack_i | timeout;
                if (!bus_ack_i) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (state_q == BUSY_IF && flush_i) begin
                    drop_d = 1'b1;
                end
                if (done) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    drop_d    = 1'b0;
                    cnt_d     = '0;
                    if (state_q == BUSY_IF) begin
                        if (!drop_eff) begin
                            if_rvalid_d = 1'b1;
                            err_d       = timeout;
                            if_rdata_d  = timeout ? '0 : bus_rdata_i;
                        end
                    end else begin
                        mem_rvalid_d = 1'b1;
                        err_d        = timeout;
                        if (timeout) begin
                            mem_rdata_d = '0;
                        end else if (!bus_we_q) begin
                            mem_rdata_d = bus_rdata_i;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            drop_q       <= 1'b0;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rvalid_q <= 1'b0;
            mem_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_rdata_q  <= mem_rdata_d;
            err_q        <= err_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign if_gnt_o     = if_gnt & resetn_i;
    assign mem_gnt_o    = mem_gnt & resetn_i;
    assign stall_o      = resetn_i & ((state_q != IDLE) | (if_req_i & mem_req_i));
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_be_o     = bus_be_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign if_rvalid_o  = if_rvalid_q;
    assign if_rdata_o   = if_rdata_q;
    assign mem_rvalid_o = mem_rvalid_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Randomized bench for toast_mem_arbiter against a transaction-level model
// (one outstanding transaction, counted busy cycles, completion effects).
module tb_toast_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          if_req, if_gnt, if_rvalid, flush;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          bus_req, bus_we, bus_ack, stall, err;
    logic [BW-1:0] bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;

    toast_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .flush_i(flush),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_be_i(mem_be),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_gnt_o(mem_gnt),
        .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
        .stall_o(stall), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one outstanding transaction and the expected registered outputs.
    bit          m_busy, m_is_mem, m_we, m_drop;
    int          m_n;
    bit          e_bus_req, e_we, e_if_rvalid, e_mem_rvalid, e_err;
    bit [BW-1:0] e_be;
    bit [AW-1:0] e_addr;
    bit [DW-1:0] e_wdata, e_if_rdata, e_mem_rdata;
    int          ack_pct;
    bit          did_rst;

    task automatic model_reset();
        m_busy = 0; m_is_mem = 0; m_we = 0; m_drop = 0; m_n = 0;
        e_bus_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
        e_if_rvalid = 0; e_if_rdata = '0; e_mem_rvalid = 0; e_mem_rdata = '0; e_err = 0;
    endtask

    task automatic check_regs();
        check("bus_req", bus_req, e_bus_req);
        check("bus_we", bus_we, e_we);
        check("bus_be", bus_be, e_be);
        check("bus_addr", bus_addr, e_addr);
        check("bus_wdata", bus_wdata, e_wdata);
        check("if_rvalid", if_rvalid, e_if_rvalid);
        check("if_rdata", if_rdata, e_if_rdata);
        check("mem_rvalid", mem_rvalid, e_mem_rvalid);
        check("mem_rdata", mem_rdata, e_mem_rdata);
        check("err", err, e_err);
    endtask

    // A requester may only assert req while it has nothing outstanding.
    task automatic drive_random();
        bit if_free, mem_free;
        if_free   = !(m_busy && !m_is_mem);
        mem_free  = !(m_busy && m_is_mem);
        if_req    = if_free && ($urandom_range(0, 99) < 40);
        mem_req   = mem_free && ($urandom_range(0, 99) < 30);
        if_addr   = $urandom;
        mem_addr  = $urandom;
        mem_we    = $urandom_range(0, 1) == 1;
        mem_be    = BW'($urandom);
        mem_wdata = $urandom;
        flush     = $urandom_range(0, 99) < 15;
        bus_ack   = $urandom_range(0, 99) < ack_pct;
        bus_rdata = $urandom;
    endtask

    task automatic check_comb();
        check("mem_gnt", mem_gnt, !m_busy && mem_req);
        check("if_gnt", if_gnt, !m_busy && if_req && !mem_req);
        check("stall", stall, m_busy || (if_req && mem_req));
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        bit to, fin;
        e_if_rvalid = 0; e_mem_rvalid = 0; e_err = 0;
        if (!m_busy) begin
            if (mem_req) begin
                m_busy = 1; m_is_mem = 1; m_we = mem_we; m_n = 0; m_drop = 0;
                e_bus_req = 1; e_we = mem_we; e_be = mem_be; e_addr = mem_addr; e_wdata = mem_wdata;
            end else if (if_req) begin
                m_busy = 1; m_is_mem = 0; m_we = 0; m_n = 0; m_drop = flush;
                e_bus_req = 1; e_we = 0; e_be = '1; e_addr = if_addr; e_wdata = '0;
            end
        end else begin
            m_n++;
            if (!m_is_mem && flush) m_drop = 1;
            to  = !bus_ack && (TMO != 0) && (m_n == TMO + 1);
            fin = bus_ack || to;
            if (fin) begin
                if (m_is_mem) begin
                    e_mem_rvalid = 1;
                    e_err = to;
                    if (to) e_mem_rdata = '0;
                    else if (!m_we) e_mem_rdata = bus_rdata;
                end else if (!m_drop) begin
                    e_if_rvalid = 1;
                    e_err = to;
                    e_if_rdata = to ? '0 : bus_rdata;
                end
                m_busy = 0; m_drop = 0; e_bus_req = 0;
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        if_req = 0; mem_req = 0; flush = 0; bus_ack = 0; mem_we = 0;
        mem_be = '0; if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
        ack_pct = 25; did_rst = 0;
        model_reset();
        @(negedge clk);
        if_req = 1; mem_req = 1;
        #1;
        check("rst_mem_gnt", mem_gnt, 1'b0);
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_stall", stall, 1'b0);
        check_regs();
        @(negedge clk);
        resetn = 1'b1; if_req = 0; mem_req = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc >= 2000 && !did_rst && m_busy && m_is_mem) begin
                resetn = 1'b0;
                mem_req = 1; if_req = 1;
                #1;
                model_reset();
                check("midrst_mem_gnt", mem_gnt, 1'b0);
                check("midrst_if_gnt", if_gnt, 1'b0);
                check("midrst_stall", stall, 1'b0);
                check_regs();
                @(negedge clk);
                resetn = 1'b1; mem_req = 0; if_req = 0;
                did_rst = 1;
                continue;
            end
            ack_pct = ((cyc / 400) % 2 == 1) ? 80 : 25;
            drive_random();
            #1;
            check_comb();
            check_regs();
            model_step();
        end
        check("midrst_reached", did_rst, 1'b1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
